// File: rtl/mcu_mem_pkg.sv
// mcu_mem_pkg: shared FSM, operation and counter encodings for the memory responder
package mcu_mem_pkg;
  localparam int CNT_W = 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;
endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x 8 storage with synchronous write and registered read, no reset
module mem_array #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  // write on enable, read the addressed word every edge
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory slave; define MEM_RANGE_CHK_EN to flag addresses >= DEPTH
module mem_responder
  import mcu_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RDRequest_i,
  input  logic       WRRequest_i,
  input  logic [7:0] ExternAddr_i,
  input  logic [7:0] ExternVal_i,
  output logic [7:0] ExternVal_o,
  output logic       Ready_o,
  output logic       Busy_o,
  output logic       Err_o
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0] state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic op, err_q, addr_err, req, done_edge, we;
  logic [7:0] addr_q, wdata_q, rdata;
  logic [AW-1:0] raddr;
  assign req = RDRequest_i | WRRequest_i;
  assign done_edge = (state == WAIT) && (cnt == '0);
  assign we = !rst && done_edge && (op == OP_WR) && !err_q;
  assign raddr = (state == IDLE) ? ExternAddr_i[AW-1:0] : addr_q[AW-1:0];
  assign Ready_o = (state == DONE);
  assign Busy_o = (state != IDLE);
`ifdef MEM_RANGE_CHK_EN
  assign addr_err = {1'b0, ExternAddr_i} >= 9'(DEPTH);
  assign Err_o = Ready_o & err_q;
`else
  assign addr_err = 1'b0;
  assign Err_o = 1'b0;
`endif
  // next state: capture in IDLE, count down in WAIT, DONE lasts one cycle
  always_comb begin
    state_nxt = (state == IDLE) ? (req ? WAIT : IDLE) :
                (state == WAIT) ? ((cnt == '0) ? DONE : WAIT) : IDLE;
  end
  // state, latency counter and read-data register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ExternVal_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) cnt <= CNT_W'(WAIT_CYCLES - 1);
      else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (done_edge && op == OP_RD) ExternVal_o <= err_q ? 8'h00 : rdata;
    end
  end
  // captured request copies; write wins when both requests are high
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      op <= WRRequest_i ? OP_WR : OP_RD;
      addr_q <= ExternAddr_i;
      wdata_q <= ExternVal_i;
      err_q <= addr_err;
    end
  end
  mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .we(we),
    .waddr(addr_q[AW-1:0]),
    .wdata(wdata_q),
    .raddr(raddr),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks on three responder configurations sharing one stimulus bus
module tb_mem_responder;
  logic clk = 1'b0, rst = 1'b1;
  logic rd = 1'b0, wr = 1'b0;
  logic [7:0] addr = '0, din = '0;
  logic [7:0] val [3];
  logic [2:0] rdy, bsy, err;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  mem_responder #(.WAIT_CYCLES(1), .DEPTH(256)) u1 (
    .clk(clk), .rst(rst), .RDRequest_i(rd), .WRRequest_i(wr), .ExternAddr_i(addr),
    .ExternVal_i(din), .ExternVal_o(val[0]), .Ready_o(rdy[0]), .Busy_o(bsy[0]), .Err_o(err[0]));
  mem_responder #(.WAIT_CYCLES(3), .DEPTH(256)) u3 (
    .clk(clk), .rst(rst), .RDRequest_i(rd), .WRRequest_i(wr), .ExternAddr_i(addr),
    .ExternVal_i(din), .ExternVal_o(val[1]), .Ready_o(rdy[1]), .Busy_o(bsy[1]), .Err_o(err[1]));
  mem_responder #(.WAIT_CYCLES(1), .DEPTH(16)) u16 (
    .clk(clk), .rst(rst), .RDRequest_i(rd), .WRRequest_i(wr), .ExternAddr_i(addr),
    .ExternVal_i(din), .ExternVal_o(val[2]), .Ready_o(rdy[2]), .Busy_o(bsy[2]), .Err_o(err[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    repeat (5) tick();
    wr = w; rd = r; addr = a; din = d;
    tick();
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic txn(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d, input int sel);
    start(w, r, a, d);
    for (int i = 0; i < 20 && !rdy[sel]; i++) tick();
    vectors++;
    if (rdy[sel] !== 1'b1) begin
      miscompares++;
      $display("FAIL txn_timeout dut=%0d addr=%h ready=%b want 1", sel, a, rdy[sel]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({val[i], rdy[i], bsy[i], err[i]} !== 11'h0) begin
        miscompares++;
        $display("FAIL reset_outputs dut=%0d got val=%h rdy=%b bsy=%b err=%b want all 0", i, val[i], rdy[i], bsy[i], err[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    repeat (5) tick();
    wr = 1'b1; addr = 8'h10; din = 8'h5A;
    tick();
    wr = 1'b0;
    vectors++;
    if ({bsy[0], rdy[0]} !== 2'b10) begin
      miscompares++;
      $display("FAIL basic_wait got bsy/rdy=%b%b want 10", bsy[0], rdy[0]);
    end
    tick();
    vectors++;
    if ({bsy[0], rdy[0], val[0]} !== {2'b11, 8'h00}) begin
      miscompares++;
      $display("FAIL basic_wr_done got bsy/rdy=%b%b val=%h want 11 00", bsy[0], rdy[0], val[0]);
    end
    tick();
    vectors++;
    if ({bsy[0], rdy[0]} !== 2'b00) begin
      miscompares++;
      $display("FAIL basic_idle got bsy/rdy=%b%b want 00", bsy[0], rdy[0]);
    end
    start(1'b0, 1'b1, 8'h10, 8'h00);
    tick();
    vectors++;
    if ({rdy[0], val[0]} !== {1'b1, 8'h5A}) begin
      miscompares++;
      $display("FAIL basic_rd got rdy=%b val=%h want 1 5a", rdy[0], val[0]);
    end
  endtask

  task automatic test_latency();
    txn(1'b1, 1'b0, 8'h40, 8'h99, 1);
    txn(1'b1, 1'b0, 8'h41, 8'h22, 1);
    repeat (5) tick();
    rd = 1'b1; addr = 8'h40;
    tick();
    rd = 1'b0; addr = 8'h41;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({bsy[1], rdy[1]} !== 2'b10) begin
        miscompares++;
        $display("FAIL latency_wait edge=%0d got bsy/rdy=%b%b want 10", k, bsy[1], rdy[1]);
      end
      tick();
    end
    vectors++;
    if ({bsy[1], rdy[1], val[1]} !== {2'b11, 8'h99}) begin
      miscompares++;
      $display("FAIL latency_done got bsy/rdy=%b%b val=%h want 11 99", bsy[1], rdy[1], val[1]);
    end
    tick();
    vectors++;
    if ({bsy[1], rdy[1]} !== 2'b00) begin
      miscompares++;
      $display("FAIL latency_idle got bsy/rdy=%b%b want 00", bsy[1], rdy[1]);
    end
  endtask

  task automatic test_priority();
    txn(1'b0, 1'b1, 8'h10, 8'h00, 0);
    txn(1'b1, 1'b1, 8'h20, 8'hA5, 0);
    vectors++;
    if (val[0] !== 8'h5A) begin
      miscompares++;
      $display("FAIL prio_val_held got %h want 5a", val[0]);
    end
    txn(1'b0, 1'b1, 8'h20, 8'h00, 0);
    vectors++;
    if (val[0] !== 8'hA5) begin
      miscompares++;
      $display("FAIL prio_rd got %h want a5", val[0]);
    end
  endtask

  task automatic test_reset_abort();
    txn(1'b1, 1'b0, 8'h30, 8'h11, 0);
    repeat (5) tick();
    wr = 1'b1; addr = 8'h30; din = 8'h77;
    tick();
    wr = 1'b0; rst = 1'b1;
    vectors++;
    if (bsy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_busy got %b want 1", bsy[0]);
    end
    tick();
    rst = 1'b0;
    vectors++;
    if ({bsy[0], rdy[0], val[0]} !== 10'h0) begin
      miscompares++;
      $display("FAIL abort_outputs got bsy/rdy=%b%b val=%h want 00 00", bsy[0], rdy[0], val[0]);
    end
    tick();
    vectors++;
    if (rdy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_ready got %b want 0", rdy[0]);
    end
    txn(1'b0, 1'b1, 8'h30, 8'h00, 0);
    vectors++;
    if (val[0] !== 8'h11) begin
      miscompares++;
      $display("FAIL abort_rd got %h want 11", val[0]);
    end
  endtask

  task automatic test_range();
    txn(1'b1, 1'b0, 8'h02, 8'h66, 2);
    txn(1'b1, 1'b0, 8'h12, 8'h3C, 2);
`ifdef MEM_RANGE_CHK_EN
    vectors++;
    if ({rdy[2], err[2]} !== 2'b11) begin
      miscompares++;
      $display("FAIL range_wr_err got rdy/err=%b%b want 11", rdy[2], err[2]);
    end
    txn(1'b0, 1'b1, 8'h02, 8'h00, 2);
    vectors++;
    if ({val[2], err[2]} !== {8'h66, 1'b0}) begin
      miscompares++;
      $display("FAIL range_no_write got val=%h err=%b want 66 0", val[2], err[2]);
    end
    txn(1'b0, 1'b1, 8'h12, 8'h00, 2);
    vectors++;
    if ({val[2], err[2]} !== {8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL range_rd_err got val=%h err=%b want 00 1", val[2], err[2]);
    end
`else
    vectors++;
    if ({rdy[2], err[2]} !== 2'b10) begin
      miscompares++;
      $display("FAIL wrap_wr got rdy/err=%b%b want 10", rdy[2], err[2]);
    end
    txn(1'b0, 1'b1, 8'h02, 8'h00, 2);
    vectors++;
    if ({val[2], err[2]} !== {8'h3C, 1'b0}) begin
      miscompares++;
      $display("FAIL wrap_rd got val=%h err=%b want 3c 0", val[2], err[2]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    repeat (5) tick();
    wr = 1'b1; addr = 8'h50; din = 8'h33;
    tick();
    tick();
    vectors++;
    if (rdy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first got rdy=%b want 1", rdy[0]);
    end
    din = 8'h44;
    tick();
    vectors++;
    if ({bsy[0], rdy[0]} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_idle got bsy/rdy=%b%b want 00", bsy[0], rdy[0]);
    end
    tick();
    wr = 1'b0;
    vectors++;
    if ({bsy[0], rdy[0]} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_second_wait got bsy/rdy=%b%b want 10", bsy[0], rdy[0]);
    end
    tick();
    vectors++;
    if (rdy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second_done got rdy=%b want 1", rdy[0]);
    end
    txn(1'b0, 1'b1, 8'h50, 8'h00, 0);
    vectors++;
    if (val[0] !== 8'h44) begin
      miscompares++;
      $display("FAIL b2b_rd got %h want 44", val[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_priority();
    test_reset_abort();
    test_range();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter WAIT_CYCLES, default 1, giving the access latency in clocks (legal range 1..15).
REQ-002 The module SHALL have parameter DEPTH, default 256, giving the number of 8-bit storage words (power of two, 2..256).
REQ-003 The module SHALL use one clock and a synchronous, active-high reset.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port RDRequest_i, input, 1 bit: read request from the kernel.
REQ-007 The module SHALL have port WRRequest_i, input, 1 bit: write request from the kernel.
REQ-008 The module SHALL have port ExternAddr_i, input, 8 bits: access address.
REQ-009 The module SHALL have port ExternVal_i, input, 8 bits: write data from the kernel.
REQ-010 The module SHALL have port ExternVal_o, output, 8 bits: read data to the kernel.
REQ-011 The module SHALL have port Ready_o, output, 1 bit: one-cycle access-complete pulse.
REQ-012 The module SHALL have port Busy_o, output, 1 bit: high while a transaction is in flight.
REQ-013 The module SHALL have port Err_o, output, 1 bit: address-range error pulse.

Function
REQ-014 The FSM SHALL have three states, IDLE, WAIT and DONE, and Busy_o SHALL be high in WAIT and DONE.
REQ-015 In IDLE, a rising edge with RDRequest_i or WRRequest_i high SHALL capture address, write data and operation, load the counter with WAIT_CYCLES-1 and enter WAIT.
REQ-016 If RDRequest_i and WRRequest_i are both high at the capture edge, the write SHALL take priority and the read SHALL be dropped.
REQ-017 In WAIT, the counter SHALL decrement each edge, and the FSM SHALL enter DONE at the edge where the counter reads 0.
REQ-018 On the edge entering DONE, a write SHALL commit to storage, and a read SHALL load ExternVal_o from storage.
REQ-019 Ready_o SHALL be high for exactly the one cycle spent in DONE, i.e. the cycle starting WAIT_CYCLES edges after the capture edge.
REQ-020 DONE SHALL always return to IDLE on the next edge.
REQ-021 A request still held high in IDLE after DONE SHALL start a new transaction, so the requester SHALL drop its request on seeing Ready_o.
REQ-022 Request, address and data changes during WAIT or DONE SHALL be ignored, because the captured copies are used.
REQ-023 ExternVal_o SHALL hold its last read value until the next read completes, and SHALL be unaffected by writes.
REQ-024 A read of an address written by the immediately preceding transaction SHALL return the newly written value.
REQ-025 Without range checking, the address SHALL be reduced to its low log2(DEPTH) bits, so addresses wrap modulo DEPTH.

Reset
REQ-026 While rst is high at an edge, the FSM SHALL go to IDLE, the counter to 0, and ExternVal_o, Ready_o, Busy_o and Err_o to 0.
REQ-027 A reset during WAIT SHALL abort the transaction with no storage write and no Ready_o pulse.
REQ-028 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-029 With MEM_RANGE_CHK_EN defined, an address >= DEPTH SHALL suppress the write, return 0x00 on a read, and pulse Err_o together with Ready_o.
REQ-030 Without MEM_RANGE_CHK_EN, Err_o SHALL be tied 0 and addresses SHALL wrap per REQ-025.

Structure
REQ-031 Package mcu_mem_pkg SHALL hold the FSM state encoding (IDLE, WAIT, DONE), the operation encoding (OP_RD, OP_WR) and the counter width constant.
REQ-032 Storage SHALL be a sub-module mem_array: DEPTH x 8, synchronous write, registered read, no reset.

Verification
REQ-033 WAIT_CYCLES=1: WR to addr 0x10 with data 0x5A, then RD of 0x10 -> Ready_o pulses one edge after each capture; ExternVal_o = 0x5A.
REQ-034 WAIT_CYCLES=3: RD captured at edge 0 -> Busy_o high from edge 0; Ready_o high only in the cycle after edge 3; the address is changed at edge 1 and the read still uses the original address.
REQ-035 RD and WR both high with addr 0x20 and data 0xA5 -> only the write occurs; a following RD of 0x20 returns 0xA5; ExternVal_o is unchanged by the write cycle.
REQ-036 rst asserted during WAIT of a WR to 0x30 with data 0x77 -> no Ready_o pulse, outputs 0; a later RD of 0x30 returns its prior value.
REQ-037 DEPTH=16: with the macro defined, WR to 0x12 -> Err_o and Ready_o pulse, no write; without the macro, WR 0x12 with 0x3C, then RD 0x02 -> 0x3C.
REQ-038 Request held high across Ready_o -> a second transaction starts in the IDLE cycle after DONE and completes WAIT_CYCLES edges later.
